// File: rtl/host_packet_read_pkg.sv
// Shared widths, descriptor/line field positions and FSM encoding for the
// host transmit packet reader.
package host_packet_read_pkg;

  localparam int BUFID_W    = 9;
  localparam int LINE_W     = 7;
  localparam int DATA_W     = 134;
  localparam int META_W     = 15;
  localparam int DESC_W     = BUFID_W + META_W;
  localparam int RADDR_W    = BUFID_W + LINE_W;

  localparam int BUFID_LSB  = 0;
  localparam int META_LSB   = 9;

  localparam int HEAD_BIT   = 133;
  localparam int TAIL_BIT   = 132;

  localparam int PAGE_LINES = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/host_packet_read_if.sv
// Descriptor intake, packet RAM read port, transmit FIFO write port and
// bufid release handshake. The slave modport is the reader block itself.
interface host_packet_read_if;
  import host_packet_read_pkg::*;

  logic [DESC_W-1:0]  iv_descriptor;
  logic               i_descriptor_wr;
  logic               o_descriptor_ready;

  logic [RADDR_W-1:0] ov_pkt_raddr;
  logic               o_pkt_rd;
  logic [DATA_W-1:0]  iv_pkt_rdata;

  logic [DATA_W-1:0]  ov_data;
  logic               o_data_wr;
  logic [META_W-1:0]  ov_pkt_meta;
  logic               i_data_fifo_alfull;

  logic [BUFID_W-1:0] ov_pkt_bufid;
  logic               o_pkt_bufid_wr;
  logic               i_pkt_bufid_ack;

  modport slave (
    input  iv_descriptor, i_descriptor_wr, iv_pkt_rdata, i_data_fifo_alfull, i_pkt_bufid_ack,
    output o_descriptor_ready, ov_pkt_raddr, o_pkt_rd, ov_data, o_data_wr, ov_pkt_meta,
           ov_pkt_bufid, o_pkt_bufid_wr
  );

  modport master (
    output iv_descriptor, i_descriptor_wr, iv_pkt_rdata, i_data_fifo_alfull, i_pkt_bufid_ack,
    input  o_descriptor_ready, ov_pkt_raddr, o_pkt_rd, ov_data, o_data_wr, ov_pkt_meta,
           ov_pkt_bufid, o_pkt_bufid_wr
  );

endinterface

// File: rtl/host_packet_read.sv
// Fetches one descriptor's packet lines from the packet RAM into the transmit FIFO, then frees the bufid.
// Latency: accept cycle, read-issue cycle, write cycle; up to one line per cycle.
// Backpressure: FIFO almost-full pauses read issue; words already in flight still land.
module host_packet_read
  import host_packet_read_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  host_packet_read_if.slave bus,
  output logic              o_err_no_tail,
  output logic [31:0]       ov_tx_pkt_cnt
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BUFID_W-1:0] r_bufid;
  logic [META_W-1:0]  r_meta;
  logic [LINE_W:0]    r_line;
  logic               r_rd_vld;
  logic               r_first;
  logic [31:0]        r_tx_cnt;

  logic               w_accept;
  logic               w_page_done;
  logic               w_issue;
  logic               w_ret;
  logic               w_tail_in;
  logic               w_end;
  logic               w_release_ack;
  logic [DATA_W-1:0]  w_line;

  // r_line counts issued reads; its MSB means all 128 lines have gone out.
  assign w_accept      = (r_state == ST_IDLE) && bus.i_descriptor_wr;
  assign w_page_done   = r_line[LINE_W];
  assign w_issue       = (r_state == ST_READ) && !bus.i_data_fifo_alfull && !w_page_done;
  assign w_ret         = r_rd_vld && (r_state == ST_READ);
  assign w_tail_in     = bus.iv_pkt_rdata[TAIL_BIT];
  assign w_end         = w_ret && (w_tail_in || w_page_done);
  assign w_release_ack = (r_state == ST_RELEASE) && bus.i_pkt_bufid_ack;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (bus.i_descriptor_wr) w_state_nxt = ST_READ;
      ST_READ:    if (w_end) w_state_nxt = ST_DRAIN;
      ST_DRAIN:   w_state_nxt = ST_RELEASE;
      ST_RELEASE: if (bus.i_pkt_bufid_ack) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bufid  <= '0;
      r_meta   <= '0;
      r_line   <= '0;
      r_rd_vld <= 1'b0;
      r_first  <= 1'b0;
      r_tx_cnt <= '0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_accept) begin
        r_bufid <= bus.iv_descriptor[BUFID_LSB +: BUFID_W];
        r_meta  <= bus.iv_descriptor[META_LSB +: META_W];
        r_line  <= '0;
        r_first <= 1'b1;
      end else begin
        if (w_issue) r_line <= r_line + 1'b1;
        if (w_ret)   r_first <= 1'b0;
      end
      if (w_release_ack) r_tx_cnt <= r_tx_cnt + 32'd1;
    end
  end

  // A return seen while the page is exhausted is line 127; it closes the packet.
  always_comb begin
    w_line           = bus.iv_pkt_rdata;
    w_line[HEAD_BIT] = bus.iv_pkt_rdata[HEAD_BIT] | r_first;
    w_line[TAIL_BIT] = bus.iv_pkt_rdata[TAIL_BIT] | w_page_done;
  end

  assign bus.o_descriptor_ready = (r_state == ST_IDLE);
  assign bus.o_pkt_rd           = w_issue;
  assign bus.ov_pkt_raddr       = w_issue ? {r_bufid, r_line[LINE_W-1:0]} : '0;
  assign bus.o_data_wr          = w_ret;
  assign bus.ov_data            = w_ret ? w_line : '0;
  assign bus.ov_pkt_meta        = (w_ret && r_first) ? r_meta : '0;
  assign bus.o_pkt_bufid_wr     = (r_state == ST_RELEASE);
  assign bus.ov_pkt_bufid       = (r_state == ST_RELEASE) ? r_bufid : '0;
  assign o_err_no_tail          = w_ret && w_page_done && !w_tail_in;
  assign ov_tx_pkt_cnt          = r_tx_cnt;

endmodule

// File: tb/tb_host_packet_read.sv
// Directed plus randomized packets against a line-list model of what the FIFO should receive.
module tb_host_packet_read;
  import host_packet_read_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        err_no_tail;
  logic [31:0] tx_cnt;

  host_packet_read_if bus ();

  host_packet_read dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .bus           (bus),
    .o_err_no_tail (err_no_tail),
    .ov_tx_pkt_cnt (tx_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0]  page [PAGE_LINES];
  logic [DATA_W-1:0]  wq[$];
  logic [RADDR_W-1:0] rq[$];
  logic [META_W-1:0]  head_meta;
  int                 n_err;
  int                 n_rd_full;
  int                 n_meta_stray;
  bit                 mon_en = 1'b0;
  int unsigned        exp_cnt = 0;

  // Packet RAM: one page is modelled; the bufid field is checked separately.
  always @(posedge clk) begin
    if (bus.o_pkt_rd) bus.iv_pkt_rdata <= page[bus.ov_pkt_raddr[LINE_W-1:0]];
  end

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (bus.o_data_wr) begin
        if (wq.size() == 0) head_meta = bus.ov_pkt_meta;
        else if (bus.ov_pkt_meta != '0) n_meta_stray++;
        wq.push_back(bus.ov_data);
      end
      if (bus.o_pkt_rd) begin
        rq.push_back(bus.ov_pkt_raddr);
        if (bus.i_data_fifo_alfull) n_rd_full++;
      end
      if (err_no_tail) n_err++;
    end
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ntail < 0 means no line of the page carries a tail flag.
  task automatic fill_page(input int ntail);
    logic [159:0] r;
    for (int i = 0; i < PAGE_LINES; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      page[i] = r[DATA_W-1:0];
      page[i][TAIL_BIT] = (i == ntail);
    end
  endtask

  task automatic run_pkt(input logic [BUFID_W-1:0] bufid, input logic [META_W-1:0] meta,
                         input int ntail, input int af_lo, input int af_hi,
                         input int ack_dly, input bit poke_desc);
    logic [DATA_W-1:0]  expq[$];
    logic [DATA_W-1:0]  w;
    logic [RADDR_W-1:0] a;
    int last;
    int cyc;
    int bad;
    fill_page(ntail);
    // Expected FIFO content: lines 0..last, head forced on the first, tail forced on the last.
    last = (ntail >= 0) ? ntail : PAGE_LINES - 1;
    for (int i = 0; i <= last; i++) begin
      w = page[i];
      if (i == 0) w[HEAD_BIT] = 1'b1;
      if (i == last) w[TAIL_BIT] = 1'b1;
      expq.push_back(w);
    end
    wq.delete(); rq.delete();
    n_err = 0; n_rd_full = 0; n_meta_stray = 0; head_meta = '0;
    mon_en = 1'b1;

    @(negedge clk);
    chk("ready_idle", {133'd0, bus.o_descriptor_ready}, 134'd1);
    bus.iv_descriptor = {meta, bufid};
    bus.i_descriptor_wr = 1'b1;
    @(negedge clk);
    bus.i_descriptor_wr = 1'b0;
    bus.iv_descriptor = '0;
    cyc = 1;
    while (!bus.o_pkt_bufid_wr && cyc < 600) begin
      bus.i_data_fifo_alfull = (cyc >= af_lo && cyc <= af_hi);
      @(negedge clk);
      cyc++;
    end
    bus.i_data_fifo_alfull = 1'b0;
    chk("release_seen", {133'd0, bus.o_pkt_bufid_wr}, 134'd1);
    chk("release_bufid", {125'd0, bus.ov_pkt_bufid}, {125'd0, bufid});

    for (int k = 0; k < ack_dly; k++) begin
      if (poke_desc) begin
        bus.iv_descriptor = {~meta, ~bufid};
        bus.i_descriptor_wr = 1'b1;
      end
      @(negedge clk);
      chk("release_hold", {124'd0, bus.o_pkt_bufid_wr, bus.ov_pkt_bufid}, {124'd1, bufid});
      chk("ready_low_in_release", {133'd0, bus.o_descriptor_ready}, 134'd0);
    end
    bus.i_descriptor_wr = 1'b0;
    bus.iv_descriptor = '0;
    bus.i_pkt_bufid_ack = 1'b1;
    @(negedge clk);
    bus.i_pkt_bufid_ack = 1'b0;
    exp_cnt++;
    chk("ready_after_ack", {132'd0, bus.o_descriptor_ready, bus.o_pkt_bufid_wr}, 134'd2);
    chk("tx_pkt_cnt", {102'd0, tx_cnt}, {102'd0, exp_cnt});
    mon_en = 1'b0;

    chk("n_writes", 134'(wq.size()), 134'(expq.size()));
    for (int i = 0; i < expq.size() && i < wq.size(); i++) chk("line_data", wq[i], expq[i]);
    chk("head_meta", {119'd0, head_meta}, {119'd0, meta});
    chk("meta_only_on_head", 134'(n_meta_stray), 134'd0);
    chk("err_no_tail_pulses", 134'(n_err), (ntail < 0) ? 134'd1 : 134'd0);
    chk("rd_while_alfull", 134'(n_rd_full), 134'd0);
    bad = 0;
    for (int i = 0; i < rq.size(); i++) begin
      a = {bufid, 7'(i)};
      if (rq[i] !== a) bad++;
    end
    chk("raddr_sequence", 134'(bad), 134'd0);
    // Without backpressure a tail before line 127 costs exactly one over-read.
    if (af_lo > af_hi)
      chk("n_reads", 134'(rq.size()), (last < PAGE_LINES - 1) ? 134'(last + 2) : 134'd128);
  endtask

  initial begin
    int lo;
    int cyc;
    rst_n = 1'b0;
    bus.iv_descriptor = '0;
    bus.i_descriptor_wr = 1'b0;
    bus.iv_pkt_rdata = '0;
    bus.i_data_fifo_alfull = 1'b0;
    bus.i_pkt_bufid_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {133'd0, bus.o_descriptor_ready}, 134'd1);
    chk("rst_rd_wr", {130'd0, bus.o_pkt_rd, bus.o_data_wr, bus.o_pkt_bufid_wr, err_no_tail}, 134'd0);
    chk("rst_buses", {bus.ov_data}, 134'd0);
    chk("rst_addr_meta", {94'd0, bus.ov_pkt_raddr, bus.ov_pkt_meta, bus.ov_pkt_bufid}, 134'd0);
    chk("rst_cnt", {102'd0, tx_cnt}, 134'd0);
    rst_n = 1'b1;

    run_pkt(9'h003, 15'h1A5, 3, 1, 0, 0, 1'b0);
    run_pkt(9'($urandom()), 15'($urandom()), 0, 1, 0, 1, 1'b0);
    run_pkt(9'($urandom()), 15'($urandom()), 9, 3, 6, 0, 1'b0);
    run_pkt(9'($urandom()), 15'($urandom()), -1, 1, 0, 2, 1'b0);
    run_pkt(9'($urandom()), 15'($urandom()), 127, 1, 0, 0, 1'b0);
    run_pkt(9'($urandom()), 15'($urandom()), 7, 1, 0, 5, 1'b1);
    for (int p = 0; p < 5; p++) begin
      lo = $urandom_range(1, 12);
      run_pkt(9'($urandom()), 15'($urandom()), $urandom_range(0, 40), lo,
              lo + $urandom_range(0, 8), $urandom_range(0, 3), 1'b0);
    end

    // Reset in the middle of a packet, just as line 5 is being read.
    fill_page(20);
    @(negedge clk);
    bus.iv_descriptor = {15'h0055, 9'h1AA};
    bus.i_descriptor_wr = 1'b1;
    @(negedge clk);
    bus.i_descriptor_wr = 1'b0;
    cyc = 0;
    while (!(bus.o_pkt_rd && bus.ov_pkt_raddr[LINE_W-1:0] == 7'd5) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_line5", {133'd0, bus.o_pkt_rd}, 134'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rd_wr", {130'd0, bus.o_pkt_rd, bus.o_data_wr, bus.o_pkt_bufid_wr, err_no_tail}, 134'd0);
    chk("midrst_data", bus.ov_data, 134'd0);
    chk("midrst_addr_meta", {94'd0, bus.ov_pkt_raddr, bus.ov_pkt_meta, bus.ov_pkt_bufid}, 134'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", {133'd0, bus.o_descriptor_ready}, 134'd1);
    chk("postrst_cnt", {102'd0, tx_cnt}, 134'd0);
    exp_cnt = 0;
    run_pkt(9'($urandom()), 15'($urandom()), 12, 2, 4, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
